// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - memory-side bus between the load/store unit and data memory
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store sequencer with alignment check and timeout
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    we,
    input  logic [2:0]              funct3,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    fault,
    output logic [31:0]             rdata,
    load_store_unit_if.master       bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state;
    logic          we_r;
    logic [2:0]    funct3_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic          fault_r;
    logic [CW-1:0] wait_cnt;
    logic          illegal;
    logic [31:0]   lane;
    logic [31:0]   load_ext;
    logic [3:0]    be;
    logic          in_access;

    // Classify the incoming request: unsupported funct3 or misaligned size.
    always_comb begin
        illegal = 1'b0;
        if (we) begin
            illegal = (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end
        if ((funct3[1:0] == 2'b01) && addr[0]) begin
            illegal = 1'b1;
        end
        if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) begin
            illegal = 1'b1;
        end
    end

    // Byte enables and lane-replicated store data from the latched request.
    always_comb begin
        be            = 4'b1111;
        bus.mem_wdata = wdata_r;
        case (funct3_r[1:0])
            2'b00: begin
                be            = 4'b0001 << addr_r[1:0];
                bus.mem_wdata = {4{wdata_r[7:0]}};
            end
            2'b01: begin
                be            = 4'b0011 << {addr_r[1], 1'b0};
                bus.mem_wdata = {2{wdata_r[15:0]}};
            end
            default: begin
                be            = 4'b1111;
                bus.mem_wdata = wdata_r;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
    always_comb begin
        lane = bus.mem_rdata >> {addr_r[1:0], 3'b000};
        case (funct3_r)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'd0, lane[7:0]};
            3'b101:  load_ext = {16'd0, lane[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    assign in_access    = (state == ACCESS);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign fault        = (state == DONE) && fault_r;
    assign bus.mem_req  = in_access;
    assign bus.mem_we   = in_access && we_r;
    assign bus.mem_be   = in_access ? be : 4'b0000;
    assign bus.mem_addr = {addr_r[31:2], 2'b00};

    // Request sequencing: latch on start, wait for ready or timeout, pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= 32'd0;
            wdata_r  <= 32'd0;
            fault_r  <= 1'b0;
            wait_cnt <= '0;
            rdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        we_r     <= we;
                        funct3_r <= funct3;
                        addr_r   <= addr;
                        wdata_r  <= wdata;
                        wait_cnt <= '0;
                        fault_r  <= illegal;
                        state    <= illegal ? DONE : ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready) begin
                        if (!we_r) begin
                            rdata <= load_ext;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CW'(TIMEOUT - 1)) begin
                            fault_r <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    fault_r <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
